// File: rtl/alu_pkg.sv
// Shared ALU control codes and multiplier state encoding.
// Imported by the execute-stage blocks that drive the shared ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_FIXA = 3'd2;
  localparam logic [2:0] ST_FIXB = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MUL  = ST_MUL,
    S_FIXA = ST_FIXA,
    S_FIXB = ST_FIXB,
    S_DONE = ST_DONE
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier borrowing the shared ALU.
// Signed results come from two high-word subtract corrections.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               alu_busy,
  output logic [WIDTH-1:0]   alu_src1,
  output logic [WIDTH-1:0]   alu_src2,
  output logic [3:0]         alu_ctrl,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  mul_state_e       state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             a_sgn_q;
  logic             b_sgn_q;
  logic             sgn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             busy_q;
  logic             valid_q;

  assign ready     = ready_q;
  assign alu_busy  = busy_q;
  assign out_valid = valid_q;
  assign product   = {hi_q, lo_q};

  // Operand/control mux toward the shared ALU, per state.
  always_comb begin
    alu_src1 = '0;
    alu_src2 = '0;
    alu_ctrl = ALU_ADD;
    unique case (1'b1)
      state_q == S_MUL: begin
        alu_src1 = hi_q;
        alu_src2 = lo_q[0] ? mcand_q : '0;
      end
      state_q == S_FIXA: begin
        alu_ctrl = ALU_SUB;
        alu_src1 = hi_q;
        alu_src2 = (sgn_q & a_sgn_q) ? mplier_q : '0;
      end
      state_q == S_FIXB: begin
        alu_ctrl = ALU_SUB;
        alu_src1 = hi_q;
        alu_src2 = (sgn_q & b_sgn_q) ? mcand_q : '0;
      end
      default: ;
    endcase
  end

  // Control FSM, datapath registers and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_sgn_q  <= 1'b0;
      b_sgn_q  <= 1'b0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            lo_q     <= op_b;
            hi_q     <= '0;
            cnt_q    <= '0;
            sgn_q    <= is_signed;
            a_sgn_q  <= op_a[WIDTH-1];
            b_sgn_q  <= op_b[WIDTH-1];
            state_q  <= S_MUL;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_MUL: begin
          // Carry only exists when a real add happened.
          {hi_q, lo_q} <= {lo_q[0] & alu_cout,
                           alu_result,
                           lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIXA;
        end
        S_FIXA: begin
          hi_q    <= alu_result;
          state_q <= S_FIXB;
        end
        S_FIXB: begin
          hi_q    <= alu_result;
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 32×32→64 multiplier controller that borrows the shared 32-bit combinational ALU for all of its arithmetic. It runs shift-add iterations with the ALU's add operation, then applies a two-step signed correction with the ALU's subtract. The block sits beside the ALU in the execute stage. While `alu_busy` is high, the datapath mux hands ALU operand and control inputs to this block.

## Interface
Parameters:
- `WIDTH`, 32: operand width; the product is 2×WIDTH.
- `CNT_W`, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: request a multiply; accepted only when `ready`=1.
- `ready` out 1: high only in IDLE.
- `is_signed` in 1: sampled with `start`; 1 = two's-complement operands.
- `op_a` in WIDTH: multiplicand, sampled on accept.
- `op_b` in WIDTH: multiplier, sampled on accept.
- `out_valid` out 1: product available.
- `out_ready` in 1: consumer accepts the product.
- `product` out 2×WIDTH: result, stable while `out_valid`=1.
- `alu_busy` out 1: this block owns the ALU.
- `alu_src1` out WIDTH: ALU source 1.
- `alu_src2` out WIDTH: ALU source 2.
- `alu_ctrl` out 4: ALU control, where [3]=A_invert, [2]=B_invert, [1:0]=operation.
- `alu_result` in WIDTH: ALU result, combinational, same cycle.
- `alu_cout` in 1: ALU carry out of bit WIDTH-1.

## Operation
Registers:
- `mcand` (WIDTH), `hi` (WIDTH), `lo` (WIDTH).
- `a_sgn`, `b_sgn`, `sgn`.
- `cnt` (CNT_W).
- `state`.

States: IDLE, MUL, FIXA, FIXB, DONE.

- **IDLE.** `ready`=1 and `alu_busy`=0.
  - On `start`: `mcand`←`op_a`, `lo`←`op_b`, `hi`←0, `cnt`←0, `sgn`←`is_signed`, `a_sgn`←`op_a`[WIDTH-1], `b_sgn`←`op_b`[WIDTH-1]. Next state is MUL.
- **MUL.** Drive `alu_ctrl`=ALU_ADD, `alu_src1`=`hi`, `alu_src2`=`lo`[0] ? `mcand` : 0.
  - Each cycle, as one 2×WIDTH+1 right shift: {`hi`,`lo`} ← {(`lo`[0] & `alu_cout`), `alu_result`, `lo`[WIDTH-1:1]}. When `lo`[0]=0 the ALU adds zero, so the carry is masked to 0.
  - `cnt`++. When `cnt`=WIDTH-1 at the edge, next state is FIXA.
- **FIXA.** `alu_ctrl`=ALU_SUB, `alu_src1`=`hi`, `alu_src2`=(`sgn` & `a_sgn`) ? original `op_b` : 0. Then `hi`←`alu_result`; next state is FIXB.
- **FIXB.** `alu_ctrl`=ALU_SUB, `alu_src1`=`hi`, `alu_src2`=(`sgn` & `b_sgn`) ? `mcand` : 0. Then `hi`←`alu_result`; next state is DONE.
  - The original `op_b` is needed in FIXA, so it is held in a separate register `mplier`.
- **DONE.** `out_valid`=1, `product`={`hi`,`lo`}. When `out_ready`=1, next state is IDLE.
- **Arithmetic.** All arithmetic is modulo 2^(2×WIDTH); overflow is impossible. FIXA and FIXB always execute, subtracting 0 for unsigned operation, so latency is fixed.
- **ALU outputs outside MUL/FIXA/FIXB.** `alu_src1`=0, `alu_src2`=0, `alu_ctrl`=ALU_ADD, `alu_busy`=0.

## Timing
- **Reset.** Asynchronous; on `rst_n`=0 the block goes to IDLE immediately. Reset values of outputs and registers:
  - `ready`=1, `out_valid`=0, `alu_busy`=0.
  - `product`=0, `alu_*`=0 except `alu_ctrl`=ALU_ADD.
  - All internal registers 0.
- **Reset mid-operation.** The operation is aborted and no `out_valid` is produced.
- **Latency.** Start accepted at edge E0. MUL occupies E1..E32, FIXA is E33, FIXB is E34. `out_valid` rises after E34, i.e. 34 cycles after accept (WIDTH+2 in general).
- **Back-to-back operation.** `start` is ignored outside IDLE. After `out_ready` is taken in DONE, `ready` returns the next cycle, so there is one bubble between consecutive products.
- **Backpressure.** `out_valid` and `product` hold indefinitely until `out_ready`=1.
- **Combinational path.** `alu_busy` is a registered state decode, high in MUL, FIXA and FIXB. The ALU path (`alu_src*` → `alu_result` → register) is a single-cycle combinational loop through the external ALU, with no registers inside it.

## Structure
- Shared package `alu_pkg`:
  - ALU control constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111.
  - State encoding localparams for IDLE..DONE.
- Single module `alu_mul_seq`; no sub-module. The ALU is instantiated by the parent and arbitrated by `alu_busy`.

## Test plan
- Unsigned, `op_a`=3, `op_b`=5 → `product`=0x0000_0000_0000_000F; `out_valid` exactly 34 cycles after accept.
- Unsigned, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001, exercising the carry path every iteration.
- Signed:
  - −3 (0xFFFFFFFD) × 7 → 0xFFFFFFFF_FFFFFFEB.
  - −1 × −1 → 0x0000_0000_0000_0001.
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `product` is stable. Assert `start` during that time → it is ignored. After `out_ready`, `ready`=1 the next cycle.
- Pull `rst_n` low at MUL cycle 17 → immediately `ready`=1, `alu_busy`=0, `out_valid`=0. A new 2×2 then yields 4.
- Bus check: `alu_busy`=1 for exactly 34 cycles per operation. `alu_ctrl`=ALU_ADD in MUL and ALU_SUB in FIXA/FIXB.
